fir10_block_parallel: RTL and testbench
=======================================

// Module: fir10_block_parallel
// PURPOSE
//  10-tap block-parallel FIR filter: each clock consumes 10 consecutive signed samples
//  packed in one 90-bit word and produces 10 filtered 24-bit results packed in 240 bits.
//  Sits between the sample source (ADC/test-vector feeder) and the downstream result sink.
//  Throughput is 10 samples/clock. No backpressure.
// PARAMETERS
//  LANES   10       samples per word; also the tap count; fixed
//  DATA_W  9        signed input sample width
//  COEF_W  11       signed coefficient width
//  OUT_W   24       signed output width per lane
//  COEFS   {1,3,8,14,18,18,14,8,3,1}  packed h[0..9], COEF_W bits each, h[0] in LSBs
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    synchronous active-low reset
//  data_in   in   90   lane k = data_in[9k+8:9k], signed; lane 0 = oldest sample
//  data_en   in   1    0 = filter mode; 1 = bypass mode
//  data_out  out  240  lane k = data_out[24k+23:24k], signed; result for input lane k
// BEHAVIOUR
//  - Sample index: word n, lane k carries x[10n+k].
//    Filter output: y[10n+k] = sum_{i=0..9} h[i]*x[10n+k-i].
//    Samples with index < 10n come from history (previous word's lanes), held in registers.
//  - Pipeline, 3 cycles, fixed:
//    edge1: register data_in and history.
//    edge2: register all 100 products (DATA_W+COEF_W = 20 bits each).
//    edge3: register the adder-tree sums.
//    data_out for a word appears 3 rising edges after that word is sampled.
//  - Arithmetic: full-precision signed. The 24-bit sum cannot overflow. No rounding and
//    no saturation, except as described under CONFIGURATION.
//  - Bypass (data_en=1): lane k output = x[10n+k] sign-extended to 24 bits, through the
//    same 3-cycle latency. The history register still updates, so switching modes is seamless.
//  - data_en is sampled with data_in in the same edge1 register and travels with its word.
//  - Reset (rst_n=0 at an edge): all pipeline, history and output registers clear to 0.
//    data_out = 0 from the next edge.
//  - Reset mid-stream discards history: the first word after reset is filtered as if all
//    prior samples were 0.
//  - Mid-stream data_en toggles affect only their own word.
//  - X on data_in is not sanitised.
// CONFIGURATION
//  FIR10_ROUND_EN defined:
//    each lane output = (sum + 2^(COEF_W-2)) >>> (COEF_W-1), sign-extended to 24 bits
//    (round-half-up, gain normalised by 1024). Bypass is unaffected. Latency unchanged.
//  FIR10_ROUND_EN undefined: full-precision sum as specified above.
// TESTING
//  1. Impulse lane 0:
//     word {lane0=1, others 0}, then zeros -> output lanes 0..9 = 1,3,8,14,18,18,14,8,3,1.
//     Next output word is all 0.
//  2. Impulse straddling words:
//     lane5=1, then zeros -> first word lanes 5..9 = 1,3,8,14,18;
//     next word lanes 0..4 = 18,14,8,3,1; all other lanes 0.
//  3. DC and extremes:
//     all lanes 100 -> steady 8800 per lane.
//     all lanes -256 -> -22528 (0xFFA800).
//     all lanes 255 -> 22440.
//  4. Latency and reset:
//     assert rst_n=0 mid-stream -> data_out = 0 next edge.
//     After release, the impulse from test 1 reproduces exactly, with no stale history.
//     The first nonzero output appears exactly 3 edges after the impulse word.
//  5. Bypass:
//     data_en=1 with lanes = 0..9 -> outputs 0..9, sign-extended.
//     Lane value -1 -> 0xFFFFFF.
//     Toggling data_en per word switches mode per word.
//  6. With FIR10_ROUND_EN:
//     all lanes 100 -> 9 per lane (8800+512 >>10).
//     Impulse 255 at lane 0 -> lane 4 = (4590+512)>>10 = 4.

Source files
------------

// File: rtl/fir10_block_parallel.sv
// ============================================================================
// Module   : fir10_block_parallel
// Purpose  : 10-tap block-parallel FIR, 10 samples in / 10 results out per clock,
//            fixed 3-cycle latency, per-word bypass via data_en.
// Options  : define FIR10_ROUND_EN for round-half-up output normalised by 2^(COEF_W-1)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir10_block_parallel #(
  parameter int LANES  = 10,
  parameter int DATA_W = 9,
  parameter int COEF_W = 11,
  parameter int OUT_W  = 24,
  parameter logic [LANES*COEF_W-1:0] COEFS = {11'd1, 11'd3, 11'd8, 11'd14, 11'd18,
                                              11'd18, 11'd14, 11'd8, 11'd3, 11'd1}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic                    data_en,
  output logic [LANES*OUT_W-1:0]  data_out
);

  localparam int PROD_W = DATA_W + COEF_W;
`ifdef FIR10_ROUND_EN
  localparam logic signed [OUT_W-1:0] RND_HALF = OUT_W'(1) <<< (COEF_W - 2);
`endif

  logic signed [DATA_W-1:0] x_d    [LANES];
  logic signed [DATA_W-1:0] x_q    [LANES];
  logic signed [DATA_W-1:0] hist_q [LANES];
  logic                     en1_q;

  logic signed [PROD_W-1:0] prod_d [LANES][LANES];
  logic signed [PROD_W-1:0] prod_q [LANES][LANES];
  logic signed [DATA_W-1:0] byp2_q [LANES];
  logic                     en2_q;

  logic signed [OUT_W-1:0]  sum_d  [LANES];
  logic signed [OUT_W-1:0]  filt_d [LANES];
  logic signed [OUT_W-1:0]  out_d  [LANES];
  logic signed [OUT_W-1:0]  out_q  [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [OUT_W-1:0] acc;

    assign x_d[k] = data_in[k*DATA_W +: DATA_W];

    for (genvar i = 0; i < LANES; i++) begin : g_tap
      localparam logic signed [COEF_W-1:0] H = COEFS[i*COEF_W +: COEF_W];
      // Taps reaching before lane 0 of the current word read the previous word.
      if (i <= k) begin : g_cur
        assign prod_d[k][i] = PROD_W'(x_q[k-i]) * PROD_W'(H);
      end else begin : g_hist
        assign prod_d[k][i] = PROD_W'(hist_q[LANES+k-i]) * PROD_W'(H);
      end
    end

    always_comb begin
      acc = '0;
      for (int i = 0; i < LANES; i++) begin
        acc = acc + OUT_W'(prod_q[k][i]);
      end
    end
    assign sum_d[k] = acc;

`ifdef FIR10_ROUND_EN
    assign filt_d[k] = (sum_d[k] + RND_HALF) >>> (COEF_W - 1);
`else
    assign filt_d[k] = sum_d[k];
`endif

    assign out_d[k] = en2_q ? OUT_W'(byp2_q[k]) : filt_d[k];
    assign data_out[k*OUT_W +: OUT_W] = out_q[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en1_q <= 1'b0;
      en2_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        x_q[k]    <= '0;
        hist_q[k] <= '0;
        byp2_q[k] <= '0;
        out_q[k]  <= '0;
        for (int i = 0; i < LANES; i++) begin
          prod_q[k][i] <= '0;
        end
      end
    end else begin
      en1_q <= data_en;
      en2_q <= en1_q;
      for (int k = 0; k < LANES; k++) begin
        x_q[k]    <= x_d[k];
        hist_q[k] <= x_q[k];
        byp2_q[k] <= x_q[k];
        out_q[k]  <= out_d[k];
        for (int i = 0; i < LANES; i++) begin
          prod_q[k][i] <= prod_d[k][i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir10_block_parallel.sv
// ============================================================================
// Module   : tb_fir10_block_parallel
// Purpose  : Scoreboard bench for fir10_block_parallel with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir10_block_parallel;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [89:0]  data_in;
  logic         data_en;
  logic [239:0] data_out;

  logic         drv_valid;
  logic [2:0]   vp;
  logic [239:0] sb [$];
  int           checks = 0;
  int           errors = 0;

  int sv [10];
  int ev [10];
  int cum [10] = '{1, 4, 12, 26, 44, 62, 76, 84, 87, 88};

  always #5 clk = ~clk;

  fir10_block_parallel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_en  (data_en),
    .data_out (data_out)
  );

  function automatic int fx(input int v);
`ifdef FIR10_ROUND_EN
    return (v + 512) >>> 10;
`else
    return v;
`endif
  endfunction

  function automatic logic [239:0] pack(input int v [10], input bit filt);
    logic [239:0] r;
    for (int k = 0; k < 10; k++) begin
      r[k*24 +: 24] = 24'(filt ? fx(v[k]) : v[k]);
    end
    return r;
  endfunction

  task automatic send(input int s [10], input bit en, input int e [10]);
    @(posedge clk);
    #2;
    for (int k = 0; k < 10; k++) data_in[k*9 +: 9] = 9'(s[k]);
    data_en   = en;
    drv_valid = 1'b1;
    sb.push_back(pack(e, !en));
  endtask

  // Word whose history is all 'prev' and whose lanes are all 'cur'.
  task automatic send_dc(input int prev, input int cur);
    for (int k = 0; k < 10; k++) begin
      sv[k] = cur;
      ev[k] = cur * cum[k] + prev * (88 - cum[k]);
    end
    send(sv, 1'b0, ev);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0; drv_valid = 1'b0; data_in = '0; data_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL %s got %h expected 0", name, data_out);
    end
    sb.delete();
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) vp <= '0;
    else        vp <= {vp[1:0], drv_valid};
  end

  always @(negedge clk) begin
    if (vp[2]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %h expected none", data_out);
      end else begin
        logic [239:0] exp_w;
        exp_w = sb.pop_front();
        if (data_out !== exp_w) begin
          errors++;
          $display("FAIL word_%0d got %h expected %h", checks, data_out, exp_w);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; drv_valid = 1'b0; data_in = '0; data_en = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset_state");

    // Impulse at lane 0, then silence
    sv = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; ev = '{1, 3, 8, 14, 18, 18, 14, 8, 3, 1};
    send(sv, 1'b0, ev);
    sv = '{default: 0}; ev = '{default: 0};
    send(sv, 1'b0, ev);

    // Impulse at lane 5 straddles into the next word
    sv = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0}; ev = '{0, 0, 0, 0, 0, 1, 3, 8, 14, 18};
    send(sv, 1'b0, ev);
    sv = '{default: 0}; ev = '{18, 14, 8, 3, 1, 0, 0, 0, 0, 0};
    send(sv, 1'b0, ev);
    ev = '{default: 0};
    send(sv, 1'b0, ev);

    // DC levels and extremes
    send_dc(0, 100);
    sv = '{default: 100};  ev = '{default: 8800};   send(sv, 1'b0, ev); send(sv, 1'b0, ev);
    send_dc(100, -256);
    sv = '{default: -256}; ev = '{default: -22528}; send(sv, 1'b0, ev);
    send_dc(-256, 255);
    sv = '{default: 255};  ev = '{default: 22440};  send(sv, 1'b0, ev);

    // Reset with words in flight and 255s in history
    send(sv, 1'b0, ev);
    send(sv, 1'b0, ev);
    do_reset("reset_midstream");
    sv = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; ev = '{1, 3, 8, 14, 18, 18, 14, 8, 3, 1};
    send(sv, 1'b0, ev);
    sv = '{default: 0}; ev = '{default: 0};
    send(sv, 1'b0, ev);

    // Bypass words interleaved with filter words
    sv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}; ev = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send(sv, 1'b1, ev);
    sv = '{default: -1}; ev = '{default: -1};
    send(sv, 1'b1, ev);
    send_dc(-1, 0);
    sv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}; ev = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send(sv, 1'b1, ev);
    sv = '{default: 0}; ev = '{474, 531, 535, 471, 353, 217, 103, 35, 9, 0};
    send(sv, 1'b0, ev);
    sv = '{-1, 5, -256, 255, 0, -7, 1, 0, 0, -1}; ev = '{-1, 5, -256, 255, 0, -7, 1, 0, 0, -1};
    send(sv, 1'b1, ev);

    @(posedge clk);
    #2;
    drv_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
